// File: rtl/cv32e40p_core_v_xif_pkg.sv
// Shared CORE-V-XIF types used by the core and by every coprocessor-side block.
// The result channel payload lives here so all users agree on its layout.
package cv32e40p_core_v_xif_pkg;

  localparam int unsigned X_ID_WIDTH  = 4;
  localparam int unsigned X_RFW_WIDTH = 32;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    logic [X_RFW_WIDTH-1:0] data;
    logic [4:0]             rd;
    logic                   we;
    logic                   float;
    logic                   exc;
    logic [5:0]             exccode;
  } x_result_t;

endpackage

// File: rtl/xif_result_fifo_pkg.sv
// Sizing helpers for the XIF result FIFO.
package xif_result_fifo_pkg;

  localparam int unsigned MaxDepth = 8;

  // A single-entry FIFO still needs a one-bit pointer.
  function automatic int unsigned ptr_width(int unsigned depth);
    return (depth > 1) ? unsigned'($clog2(depth)) : 1;
  endfunction

  function automatic int unsigned cnt_width(int unsigned depth);
    return unsigned'($clog2(depth + 1));
  endfunction

endpackage

// File: rtl/xif_result_fifo_if.sv
// One XIF result channel: valid/ready handshake plus the result payload.
interface xif_result_fifo_if;
  import cv32e40p_core_v_xif_pkg::*;

  logic      valid;
  logic      ready;
  x_result_t result;

  modport master (output valid, output result, input ready);
  modport slave  (input valid, input result, output ready);
endinterface

// File: rtl/xif_result_fifo.sv
// Registered result FIFO between a coprocessor result port and the core result port.
// No fall-through: outputs depend only on registered state, so ready/valid never loop.
module xif_result_fifo
  import cv32e40p_core_v_xif_pkg::*;
  import xif_result_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         x_result_valid_i,
  output logic                         x_result_ready_o,
  input  x_result_t                    x_result_i,
  output logic                         x_result_valid_o,
  input  logic                         x_result_ready_i,
  output x_result_t                    x_result_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PtrW = ptr_width(DEPTH);
  localparam int unsigned CntW = cnt_width(DEPTH);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  x_result_t       mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            push, pop;

  function automatic logic [PtrW-1:0] next_ptr(logic [PtrW-1:0] ptr);
    return (ptr == PtrLast) ? '0 : ptr + PtrW'(1);
  endfunction

  // Ready is a pure function of occupancy, so a pop never frees a slot in the same cycle.
  assign x_result_ready_o = (count_q < CntFull);
  assign x_result_valid_o = (count_q != '0);
  assign x_result_o       = mem_q[rd_ptr_q];
  assign count_o          = count_q;

  assign push = x_result_valid_i & x_result_ready_o;
  assign pop  = x_result_valid_o & x_result_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= x_result_i;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_xif_result_fifo.sv
// Directed bench for xif_result_fifo: vector table on a DEPTH=2 instance, corner
// sequences for reset, and an in-order streaming check on a DEPTH=3 instance.
module tb_xif_result_fifo;
  import cv32e40p_core_v_xif_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush2 = 1'b0;
  logic       flush3 = 1'b0;
  logic [1:0] cnt2, cnt3;

  int n_tests = 0;
  int n_fail  = 0;

  xif_result_fifo_if up2 ();
  xif_result_fifo_if dn2 ();
  xif_result_fifo_if up3 ();
  xif_result_fifo_if dn3 ();

  always #5 clk = ~clk;

  xif_result_fifo #(.DEPTH(2)) dut2 (
    .clk_i            (clk),
    .rst_i            (rst),
    .flush_i          (flush2),
    .x_result_valid_i (up2.valid),
    .x_result_ready_o (up2.ready),
    .x_result_i       (up2.result),
    .x_result_valid_o (dn2.valid),
    .x_result_ready_i (dn2.ready),
    .x_result_o       (dn2.result),
    .count_o          (cnt2)
  );

  xif_result_fifo #(.DEPTH(3)) dut3 (
    .clk_i            (clk),
    .rst_i            (rst),
    .flush_i          (flush3),
    .x_result_valid_i (up3.valid),
    .x_result_ready_o (up3.ready),
    .x_result_i       (up3.result),
    .x_result_valid_o (dn3.valid),
    .x_result_ready_i (dn3.ready),
    .x_result_o       (dn3.result),
    .count_o          (cnt3)
  );

  typedef struct {
    logic        flush, valid, ready;
    logic [3:0]  id;
    logic [31:0] data;
    logic        ev, er;
    logic [1:0]  ec;
    logic [3:0]  eid;
    logic [31:0] edata;
  } vec_t;

  vec_t vecs[19];

  function automatic x_result_t mk_res(logic [3:0] id, logic [31:0] data);
    x_result_t r;
    r.id      = id;
    r.data    = data;
    r.rd      = 5'(id) + 5'd1;
    r.we      = 1'b1;
    r.float   = id[0];
    r.exc     = id[1];
    r.exccode = 6'(id) ^ 6'h2a;
    return r;
  endfunction

  function automatic vec_t mk(logic fl, logic v, logic r, logic [3:0] id, logic [31:0] d,
                              logic ev, logic er, logic [1:0] ec, logic [3:0] eid,
                              logic [31:0] ed);
    vec_t t;
    t.flush = fl; t.valid = v; t.ready = r; t.id = id; t.data = d;
    t.ev = ev; t.er = er; t.ec = ec; t.eid = eid; t.edata = ed;
    return t;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int         next_id;
    int         exp_rx;
    logic       p3, q3;

    vecs[0]  = mk(0, 1, 1, 4'd1, 32'hDEADBEEF, 0, 1, 2'd0, 4'd0, 32'h0);
    vecs[1]  = mk(0, 0, 1, 4'd0, 32'h0,        1, 1, 2'd1, 4'd1, 32'hDEADBEEF);
    vecs[2]  = mk(0, 0, 0, 4'd0, 32'h0,        0, 1, 2'd0, 4'd0, 32'h0);
    vecs[3]  = mk(0, 1, 0, 4'd1, 32'h11,       0, 1, 2'd0, 4'd0, 32'h0);
    vecs[4]  = mk(0, 1, 0, 4'd2, 32'h22,       1, 1, 2'd1, 4'd1, 32'h11);
    vecs[5]  = mk(0, 1, 0, 4'd3, 32'h33,       1, 0, 2'd2, 4'd1, 32'h11);
    vecs[6]  = mk(0, 1, 1, 4'd3, 32'h33,       1, 0, 2'd2, 4'd1, 32'h11);
    vecs[7]  = mk(0, 1, 0, 4'd3, 32'h33,       1, 1, 2'd1, 4'd2, 32'h22);
    vecs[8]  = mk(0, 0, 1, 4'd0, 32'h0,        1, 0, 2'd2, 4'd2, 32'h22);
    vecs[9]  = mk(0, 0, 1, 4'd0, 32'h0,        1, 1, 2'd1, 4'd3, 32'h33);
    vecs[10] = mk(0, 1, 0, 4'd4, 32'h44,       0, 1, 2'd0, 4'd0, 32'h0);
    vecs[11] = mk(0, 1, 0, 4'd5, 32'h55,       1, 1, 2'd1, 4'd4, 32'h44);
    vecs[12] = mk(1, 1, 1, 4'd6, 32'h66,       1, 0, 2'd2, 4'd4, 32'h44);
    vecs[13] = mk(0, 0, 1, 4'd0, 32'h0,        0, 1, 2'd0, 4'd0, 32'h0);
    vecs[14] = mk(1, 1, 0, 4'd8, 32'h88,       0, 1, 2'd0, 4'd0, 32'h0);
    vecs[15] = mk(0, 0, 1, 4'd0, 32'h0,        0, 1, 2'd0, 4'd0, 32'h0);
    vecs[16] = mk(0, 1, 1, 4'd9, 32'h99,       0, 1, 2'd0, 4'd0, 32'h0);
    vecs[17] = mk(0, 0, 1, 4'd0, 32'h0,        1, 1, 2'd1, 4'd9, 32'h99);
    vecs[18] = mk(0, 0, 0, 4'd0, 32'h0,        0, 1, 2'd0, 4'd0, 32'h0);

    up2.valid = 1'b0; up2.result = '0; dn2.ready = 1'b0;
    up3.valid = 1'b0; up3.result = '0; dn3.ready = 1'b0;

    // Reset state of both instances
    #2;
    check("rst_valid2", 64'(dn2.valid), 64'd0);
    check("rst_ready2", 64'(up2.ready), 64'd1);
    check("rst_count2", 64'(cnt2), 64'd0);
    check("rst_result2", 64'(dn2.result), 64'd0);
    check("rst_valid3", 64'(dn3.valid), 64'd0);
    check("rst_count3", 64'(cnt3), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table: expectations are the state seen before the edge that applies the inputs
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      flush2     = vecs[i].flush;
      up2.valid  = vecs[i].valid;
      up2.result = mk_res(vecs[i].id, vecs[i].data);
      dn2.ready  = vecs[i].ready;
      #1;
      check($sformatf("v%0d_valid", i), 64'(dn2.valid), 64'(vecs[i].ev));
      check($sformatf("v%0d_ready", i), 64'(up2.ready), 64'(vecs[i].er));
      check($sformatf("v%0d_count", i), 64'(cnt2), 64'(vecs[i].ec));
      if (vecs[i].ev)
        check($sformatf("v%0d_result", i), 64'(dn2.result),
              64'(mk_res(vecs[i].eid, vecs[i].edata)));
    end

    // Half-cycle reset pulse with one entry buffered
    @(negedge clk);
    flush2 = 1'b0; up2.valid = 1'b1; up2.result = mk_res(4'd10, 32'hAAAA); dn2.ready = 1'b0;
    @(negedge clk);
    up2.valid = 1'b0;
    #1;
    check("pre_rst_valid", 64'(dn2.valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(dn2.valid), 64'd0);
    check("async_rst_count", 64'(cnt2), 64'd0);
    check("async_rst_ready", 64'(up2.ready), 64'd1);
    check("async_rst_result", 64'(dn2.result), 64'd0);
    #5;
    rst = 1'b0;
    @(negedge clk);
    up2.valid = 1'b1; up2.result = mk_res(4'd7, 32'h7777_0007); dn2.ready = 1'b0;
    #1;
    check("post_rst_ready", 64'(up2.ready), 64'd1);
    check("post_rst_valid", 64'(dn2.valid), 64'd0);
    @(negedge clk);
    up2.valid = 1'b0; dn2.ready = 1'b1;
    #1;
    check("post_rst_valid7", 64'(dn2.valid), 64'd1);
    check("post_rst_result7", 64'(dn2.result), 64'(mk_res(4'd7, 32'h7777_0007)));
    @(negedge clk);
    dn2.ready = 1'b0;
    #1;
    check("post_rst_drain", 64'(cnt2), 64'd0);

    // DEPTH=3 streaming with random backpressure; pointers wrap several times
    next_id = 0;
    exp_rx  = 0;
    for (int cyc = 0; cyc < 300 && exp_rx < 10; cyc++) begin
      @(negedge clk);
      up3.valid  = (next_id < 10);
      up3.result = mk_res(4'(next_id), 32'hC0DE_0000 + 32'(next_id));
      dn3.ready  = 1'($urandom_range(0, 1));
      #1;
      p3 = up3.valid & up3.ready;
      q3 = dn3.valid & dn3.ready;
      if (q3) begin
        check($sformatf("stream_id%0d", exp_rx), 64'(dn3.result),
              64'(mk_res(4'(exp_rx), 32'hC0DE_0000 + 32'(exp_rx))));
        exp_rx++;
      end
      if (p3) next_id++;
    end
    check("stream_all_delivered", 64'(exp_rx), 64'd10);
    @(negedge clk);
    up3.valid = 1'b0; dn3.ready = 1'b0;
    #1;
    check("stream_empty", 64'(cnt3), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/xif_result_fifo.md
XIF_RESULT_FIFO -- requirements
Module: xif_result_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of buffered result entries (legal range 1..8, non-power-of-2 allowed).
REQ-002 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port flush_i  input  1  synchronous discard of all buffered entries.
REQ-005 SHALL have port x_result_valid_i  input  1  upstream (coprocessor) result valid.
REQ-006 SHALL have port x_result_ready_o  output  1  FIFO can accept a result.
REQ-007 SHALL have port x_result_i  input  x_result_t  upstream result payload: id, data, rd, we, float, exc, exccode.
REQ-008 SHALL have port x_result_valid_o  output  1  downstream (core) result valid.
REQ-009 SHALL have port x_result_ready_i  input  1  core accepts the result.
REQ-010 SHALL have port x_result_o  output  x_result_t  head-of-FIFO payload.
REQ-011 SHALL have port count_o  output  $clog2(DEPTH+1)  current occupancy.

Function
REQ-012 SHALL push when x_result_valid_i and x_result_ready_o are both 1, and pop when x_result_valid_o and x_result_ready_i are both 1.
REQ-013 SHALL drive x_result_ready_o = (count_o < DEPTH), with no combinational path from x_result_ready_i or x_result_valid_i.
REQ-014 SHALL drive x_result_valid_o = (count_o != 0) from registered state only; no fall-through, so minimum latency is 1 cycle from push to x_result_valid_o.
REQ-015 SHALL drive x_result_o from the head storage entry; x_result_o SHALL remain stable while x_result_valid_o is 1 and x_result_ready_i is 0.
REQ-016 SHALL deliver entries strictly in push order with every payload field unmodified.
REQ-017 SHALL implement read/write pointers of width $clog2(DEPTH), or 1 bit if DEPTH=1, that wrap from DEPTH-1 to 0.
REQ-018 SHALL update count_o by +1 on push only, -1 on pop only, and leave it unchanged on simultaneous push and pop.
REQ-019 When full, a pop in a cycle SHALL NOT permit a push in that cycle; ready_o rises the following cycle.
REQ-020 When empty, a push SHALL NOT be visible on x_result_valid_o until the next cycle.
REQ-021 On flush_i=1 the next state SHALL be empty (pointers 0, count 0); any push or pop in that cycle SHALL be discarded, and flush has priority.
REQ-022 SHALL never overwrite an unpopped entry and never decrement count below 0.

Reset
REQ-023 On rst_i=1, asynchronously: pointers=0, count_o=0, x_result_valid_o=0, x_result_ready_o=1, all storage and x_result_o=0.
REQ-024 Reset asserted mid-transfer SHALL discard all entries; the first cycle after deassertion SHALL accept a push.

Structure
REQ-025 x_result_t SHALL be taken from the shared cv32e40p_core_v_xif_pkg; no local redefinition.
REQ-026 SHALL be a single module with no sub-modules; storage is a DEPTH-entry array of x_result_t.
REQ-027 SHALL be instantiable between the coprocessor result outputs and the core result inputs without changing either side's ports.

Verification
REQ-028 With DEPTH=2, push id=1, data=0xDEADBEEF with ready_i=1 -> valid_o=1 one cycle later with identical payload, then count_o returns to 0.
REQ-029 With ready_i=0, push ids 1, 2 -> ready_o=0 and count_o=2; a third valid_i is held off; after setting ready_i=1, ids 1, 2, 3 emerge in order.
REQ-030 When full, assert ready_i=1 while valid_i=1 -> pop of id 1 occurs with no same-cycle push; the push is accepted the next cycle; count_o goes 2->1->2.
REQ-031 With DEPTH=3, run 10 back-to-back push/pop with random ready_i -> all ids 0..9 are delivered in order, and pointers wrap without loss.
REQ-032 With count_o=2, assert flush_i together with a push -> the next cycle count_o=0, valid_o=0, and the pushed entry is never delivered.
REQ-033 With 1 entry buffered and ready_i=0, pulse rst_i for a half-cycle -> valid_o=0 immediately; after release a new push (id=7) is delivered correctly.
